elevator_scan_ctrl: RTL
=======================

ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 6, number of served floors (legal range 2..64).
REQ-002 SHALL have parameter MOVE_CYCLES, default 4, clk cycles to travel one floor (>=1).
REQ-003 SHALL have parameter DOOR_CYCLES, default 3, clk cycles the door stays open (>=1).
REQ-004 SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-007 SHALL have port floor_req, input, NUM_FLOORS, per-floor call buttons, already synchronous to clk.
REQ-008 SHALL have port cur_floor, output, FLOOR_W = max(1, clog2(NUM_FLOORS)), current floor index.
REQ-009 SHALL have port dir, output, 2, direction: 00 idle, 01 up, 10 down (11 never driven).
REQ-010 SHALL have port door_open, output, 1, high while doors are open.
REQ-011 SHALL have port arrive, output, 1, one-cycle pulse when cur_floor changes.
REQ-012 SHALL have port pending, output, NUM_FLOORS, latched outstanding requests.

Function
REQ-013 SHALL latch pending[i] on the cycle after a rising edge of floor_req[i]; a held-high level sets it only once.
REQ-014 SHALL clear pending[i] on entry to DOOR at floor i; a same-cycle set and clear of that bit resolves to clear.
REQ-015 SHALL implement FSM states IDLE, MOVE, DOOR; dir = 00 in IDLE; door_open = 1 only in DOOR.
REQ-016 IDLE: pending[cur_floor] -> DOOR; else any pending above -> MOVE, dir up; else any below -> MOVE, dir down; up has priority.
REQ-017 MOVE: cur_floor SHALL step by +/-1 after exactly MOVE_CYCLES cycles in MOVE, with arrive pulsed on that same cycle.
REQ-018 MOVE, on step: if pending[new floor] -> DOOR; else remain in MOVE in the same direction and reload the timer.
REQ-019 DOOR: door_open SHALL last exactly DOOR_CYCLES cycles.
REQ-020 DOOR: a rising edge on floor_req[cur_floor] SHALL NOT set pending and SHALL restart the door timer.
REQ-021 DOOR exit: requests ahead in the last direction -> MOVE in that direction; else requests behind -> MOVE reversed; else IDLE, dir 00.
REQ-022 cur_floor SHALL never leave 0..NUM_FLOORS-1; no MOVE is started toward a floor with no pending requests beyond it.
REQ-023 Requests at other floors SHALL be latched in every state.

Reset
REQ-024 While reset = 0: cur_floor 0, dir 00, door_open 0, arrive 0, pending all 0, state IDLE, timer 0, last direction up, edge-detect history 0.
REQ-025 Reset asserted mid-MOVE or mid-DOOR SHALL take effect immediately and discard all requests.

Structure
REQ-026 Shared package elevator_pkg SHALL hold the FSM state enum, the 2-bit dir encoding constants, and the FLOOR_W function.
REQ-027 A sub-module elevator_timer SHALL be used: a loadable down-counter with load, value and done outputs, shared by MOVE and DOOR.
REQ-028 Above/below request detection SHALL be combinational masking of pending against cur_floor inside elevator_scan_ctrl.

Verification (defaults NUM_FLOORS=6, MOVE_CYCLES=4, DOOR_CYCLES=3)
REQ-029 Reset: drive reset=0 mid-operation -> cur_floor 0, dir 00, door_open 0, pending 000000 asynchronously.
REQ-030 Idle at floor 0, pulse floor_req[5] -> dir 01, five arrive pulses 4 cycles apart, cur_floor 5, door_open for 3 cycles, then dir 00, pending 000000.
REQ-031 Idle at floor 0, pulse floor_req[0] -> DOOR with door_open 3 cycles, no arrive, cur_floor stays 0.
REQ-032 SCAN ordering: request 5 from floor 0; request 2 while between floors 0 and 1; request 1 during the stop at 5 -> stops at 2, then 5, then reverses (dir 10) to 1.
REQ-033 Door hold: re-pulse floor_req[cur_floor] on the 2nd door cycle -> door_open stays high 3 cycles after the pulse, pending bit stays 0.
REQ-034 Hold floor_req[3] high for 40 cycles from floor 0 -> exactly one visit to floor 3, then IDLE with pending 000000.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Floor index width; a two-floor building still needs one bit.
    function automatic int floor_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by the travel and door phases.
// Latency: load takes effect on the next clk edge; done is combinational on value.
// Backpressure: none; counts down freely and parks at zero.
module elevator_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    // Load wins over counting; stop at zero so done stays asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: latches call buttons, travels floor by floor, opens doors.
// Latency: request latched one cycle after its rising edge; MOVE_CYCLES per floor.
// Backpressure: none; call buttons are edge-detected and held in pending until served.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 6,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_FLOORS-1:0]          floor_req,
    output logic [floor_w(NUM_FLOORS)-1:0] cur_floor,
    output logic [1:0]                     dir,
    output logic                           door_open,
    output logic                           arrive,
    output logic [NUM_FLOORS-1:0]          pending
);

    localparam int FLOOR_W = floor_w(NUM_FLOORS);
    localparam int TMAX    = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW      = $clog2(TMAX + 1);
    // Timer counts load..0 inclusive, so load one less than the phase length.
    localparam logic [TW-1:0] MOVE_LD = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = NUM_FLOORS'(1);

    state_t                  state, state_n;
    logic [1:0]              dir_n;
    logic                    last_up, last_up_n;
    logic [FLOOR_W-1:0]      floor_n, step_floor;
    logic                    arrive_n;
    logic [NUM_FLOORS-1:0]   req_q, rise, set_vec, clr_vec;
    logic [NUM_FLOORS-1:0]   cur_onehot, step_onehot, above, below;
    logic                    door_hit;
    logic                    tmr_load, tmr_done;
    logic [TW-1:0]           tmr_val, timer_value_unused;

    elevator_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (timer_value_unused),
        .done     (tmr_done)
    );

    // Position masks: floors strictly above / below the car.
    assign cur_onehot  = ONE_HOT0 << cur_floor;
    assign above       = pending & ~((cur_onehot << 1) - ONE_HOT0);
    assign below       = pending & (cur_onehot - ONE_HOT0);
    assign step_floor  = (dir == DIR_DOWN) ? cur_floor - FLOOR_W'(1) : cur_floor + FLOOR_W'(1);
    assign step_onehot = ONE_HOT0 << step_floor;

    // Edge detection; the open door's own button only extends the door.
    assign rise     = floor_req & ~req_q;
    assign door_hit = (state == ST_DOOR) && |(rise & cur_onehot);
    assign set_vec  = (state == ST_DOOR) ? (rise & ~cur_onehot) : rise;

    assign door_open = (state == ST_DOOR);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, timer control and the floor/direction updates.
    always_comb begin
        state_n   = state;
        dir_n     = dir;
        last_up_n = last_up;
        floor_n   = cur_floor;
        arrive_n  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = MOVE_LD;
        clr_vec   = '0;
        case (state)
            ST_IDLE: begin
                if (|(pending & cur_onehot)) begin
                    state_n  = ST_DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                    clr_vec  = cur_onehot;
                end else if (|above) begin
                    state_n   = ST_MOVE;
                    dir_n     = DIR_UP;
                    last_up_n = 1'b1;
                    tmr_load  = 1'b1;
                end else if (|below) begin
                    state_n   = ST_MOVE;
                    dir_n     = DIR_DOWN;
                    last_up_n = 1'b0;
                    tmr_load  = 1'b1;
                end
            end
            ST_MOVE: begin
                if (tmr_done) begin
                    floor_n  = step_floor;
                    arrive_n = 1'b1;
                    tmr_load = 1'b1;
                    if (|(pending & step_onehot)) begin
                        state_n = ST_DOOR;
                        tmr_val = DOOR_LD;
                        clr_vec = step_onehot;
                    end
                end
            end
            ST_DOOR: begin
                if (door_hit) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (tmr_done) begin
                    if (last_up ? |above : |below) begin
                        state_n  = ST_MOVE;
                        dir_n    = last_up ? DIR_UP : DIR_DOWN;
                        tmr_load = 1'b1;
                    end else if (last_up ? |below : |above) begin
                        state_n   = ST_MOVE;
                        dir_n     = last_up ? DIR_DOWN : DIR_UP;
                        last_up_n = ~last_up;
                        tmr_load  = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        dir_n   = DIR_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                dir_n   = DIR_IDLE;
            end
        endcase
    end

    // Datapath registers; a clear on door entry beats a same-cycle set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_floor <= '0;
            dir       <= DIR_IDLE;
            last_up   <= 1'b1;
            arrive    <= 1'b0;
            pending   <= '0;
            req_q     <= '0;
        end else begin
            cur_floor <= floor_n;
            dir       <= dir_n;
            last_up   <= last_up_n;
            arrive    <= arrive_n;
            pending   <= (pending | set_vec) & ~clr_vec;
            req_q     <= floor_req;
        end
    end

endmodule
